// File: rtl/count_arbiter.sv
// count_arbiter: two-requester round-robin arbiter that grants a shared
// mod-5 counter for one full run (Q = 0..4) at a time.
// The owner may give up the counter early by dropping its request.
// A run that finishes pulses DONE for one cycle. A run that is given up
// pulses ABORT for one cycle.
// Every output is driven directly by a flop.
module count_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic [2:0] q,
   output logic       busy,
   output logic       owner,
   output logic       done,
   output logic       abort
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [2:0] Q_LAST = 3'd4;

   state_t     state_reg, state_next;
   logic [2:0] q_reg, q_next;
   logic [1:0] gnt_reg, gnt_next;
   logic       busy_reg, busy_next;
   logic       owner_reg, owner_next;
   logic       last_reg, last_next;
   logic       done_reg, done_next;
   logic       abort_reg, abort_next;
   logic       pick;

   // State and output registers; reset drops any run in progress without a pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         q_reg     <= 3'd0;
         gnt_reg   <= 2'b00;
         busy_reg  <= 1'b0;
         owner_reg <= 1'b0;
         last_reg  <= 1'b1;   // so that the first contended grant goes to requester 0
         done_reg  <= 1'b0;
         abort_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         q_reg     <= q_next;
         gnt_reg   <= gnt_next;
         busy_reg  <= busy_next;
         owner_reg <= owner_next;
         last_reg  <= last_next;
         done_reg  <= done_next;
         abort_reg <= abort_next;
      end
   end

   // Next-state logic: arbitrate in IDLE, count or terminate in RUN
   always_comb begin
      state_next = state_reg;
      q_next     = q_reg;
      gnt_next   = gnt_reg;
      busy_next  = busy_reg;
      owner_next = owner_reg;
      last_next  = last_reg;
      done_next  = 1'b0;
      abort_next = 1'b0;
      pick       = 1'b0;

      case (state_reg)
         IDLE: begin
            q_next    = 3'd0;
            gnt_next  = 2'b00;
            busy_next = 1'b0;
            if (req != 2'b00) begin
               // Under contention, grant the requester that did not run last
               pick       = (req == 2'b11) ? ~last_reg : req[1];
               state_next = RUN;
               gnt_next   = pick ? 2'b10 : 2'b01;
               owner_next = pick;
               busy_next  = 1'b1;
            end
         end
         RUN: begin
            if (!req[owner_reg]) begin
               // The owner gave up the counter, possibly on its very last count
               state_next = IDLE;
               q_next     = 3'd0;
               gnt_next   = 2'b00;
               busy_next  = 1'b0;
               last_next  = owner_reg;
               abort_next = 1'b1;
            end else if (q_reg == Q_LAST) begin
               state_next = IDLE;
               q_next     = 3'd0;
               gnt_next   = 2'b00;
               busy_next  = 1'b0;
               last_next  = owner_reg;
               done_next  = 1'b1;
            end else begin
               q_next = q_reg + 3'd1;
            end
         end
         default: begin
            state_next = IDLE;
            q_next     = 3'd0;
            gnt_next   = 2'b00;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign gnt   = gnt_reg;
   assign q     = q_reg;
   assign busy  = busy_reg;
   assign owner = owner_reg;
   assign done  = done_reg;
   assign abort = abort_reg;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter: hand-computed output vectors per cycle,
// plus invariant checks under random requests.
module tb_count_arbiter;

   logic       clk;
   logic       reset;
   logic [1:0] req;
   logic [1:0] gnt;
   logic [2:0] q;
   logic       busy;
   logic       owner;
   logic       done;
   logic       abort;

   int n_checks;
   int n_fail;

   count_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .gnt   (gnt),
      .q     (q),
      .busy  (busy),
      .owner (owner),
      .done  (done),
      .abort (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single point of comparison: counts it and reports a mismatch
   task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected output vector {gnt, q, busy, owner, done, abort}
   function automatic logic [15:0] vec(input logic [1:0] g, input logic [2:0] qv,
                                       input logic b, input logic o,
                                       input logic d, input logic a);
      return {7'd0, g, qv, b, o, d, a};
   endfunction

   function automatic logic [15:0] outs();
      return {7'd0, gnt, q, busy, owner, done, abort};
   endfunction

   // Advance one clock; sample 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req   = 2'b00;
      step();
      check_value("reset_state", outs(), vec(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      req      = 2'b00;
      #12;

      // Single requester 0: full run then DONE
      do_reset();
      req = 2'b01;
      for (int k = 0; k < 5; k++) begin
         step();
         check_value($sformatf("single_run_q%0d", k), outs(), vec(2'b01, 3'(k), 1'b1, 1'b0, 1'b0, 1'b0));
      end
      step();
      check_value("single_done", outs(), vec(2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      req = 2'b00;
      step();
      check_value("single_idle", outs(), vec(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      $display("transaction: single requester run complete");

      // Both requesting continuously: grants alternate 0,1,0
      do_reset();
      req = 2'b11;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 5; k++) begin
            step();
            check_value($sformatf("rr_run%0d_q%0d", r, k), outs(),
                        vec((r % 2 == 0) ? 2'b01 : 2'b10, 3'(k), 1'b1, 1'(r % 2), 1'b0, 1'b0));
         end
         step();
         check_value($sformatf("rr_run%0d_done", r), outs(), vec(2'b00, 3'd0, 1'b0, 1'(r % 2), 1'b1, 1'b0));
         $display("transaction: round-robin run %0d owner %0d", r, r % 2);
      end

      // Requester 1 aborts at Q=2, then contention goes to requester 0
      do_reset();
      req = 2'b10;
      for (int k = 0; k < 3; k++) begin
         step();
         check_value($sformatf("abort_run_q%0d", k), outs(), vec(2'b10, 3'(k), 1'b1, 1'b1, 1'b0, 1'b0));
      end
      req = 2'b00;
      step();
      check_value("abort_pulse", outs(), vec(2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1));
      req = 2'b11;
      step();
      check_value("abort_then_grant0", outs(), vec(2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      req = 2'b00;
      step();
      check_value("abort_owner0", outs(), vec(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
      step();
      check_value("abort_pulse_single", outs(), vec(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      $display("transaction: abort at Q=2 and regrant");

      // No preemption: requester 1 rises at Q=3 of owner 0
      do_reset();
      req = 2'b01;
      for (int k = 0; k < 4; k++) begin
         step();
         check_value($sformatf("nopre_q%0d", k), outs(), vec(2'b01, 3'(k), 1'b1, 1'b0, 1'b0, 1'b0));
      end
      req = 2'b11;
      step();
      check_value("nopre_q4", outs(), vec(2'b01, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0));
      step();
      check_value("nopre_done", outs(), vec(2'b00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      step();
      check_value("nopre_grant1", outs(), vec(2'b10, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
      $display("transaction: no preemption, requester 1 granted after gap");
      // Owner 1 drops its request exactly at Q=4: ABORT, not DONE
      for (int k = 1; k < 5; k++) begin
         step();
         check_value($sformatf("late_abort_q%0d", k), outs(), vec(2'b10, 3'(k), 1'b1, 1'b1, 1'b0, 1'b0));
      end
      req = 2'b01;
      step();
      check_value("late_abort", outs(), vec(2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1));
      req = 2'b00;
      $display("transaction: abort at Q=4");

      // Asynchronous reset in the middle of a run owned by requester 1
      do_reset();
      req = 2'b10;
      for (int k = 0; k < 4; k++) begin
         step();
         check_value($sformatf("mid_rst_q%0d", k), outs(), vec(2'b10, 3'(k), 1'b1, 1'b1, 1'b0, 1'b0));
      end
      #2;
      reset = 1'b0;
      #1;
      check_value("async_reset_immediate", outs(), vec(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      step();
      check_value("async_reset_held", outs(), vec(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      reset = 1'b1;
      req   = 2'b11;
      step();
      check_value("post_reset_grant0", outs(), vec(2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      $display("transaction: asynchronous reset mid-run");

      // Random requests: structural invariants every cycle
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         req = 2'($urandom_range(0, 3));
         step();
         check_value("rand_onehot", 16'($onehot0(gnt)), 16'd1);
         check_value("rand_q_range", 16'(q <= 3'd4), 16'd1);
         check_value("rand_busy", 16'(busy), 16'(|gnt));
         check_value("rand_done_abort", 16'(done & abort), 16'd0);
      end
      $display("transaction: random stimulus 2000 cycles");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
